// File: rtl/feedback_loop_decimator.sv
// feedback_loop_decimator
// Collects 2^DECIM_LOG2 accepted signed samples into a block, computes the
// floor-rounded block mean and queues it in a small FIFO with a valid/ready
// output. Upstream cannot stall: a result that finds the FIFO full (with no
// pop at the same edge) is discarded and recorded in a sticky overflow flag.
module feedback_loop_decimator #(
    parameter int DATA_W     = 8,
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          system1000,
    input  logic                          system1000_rstn,
    input  logic                          clr_i,
    input  logic                          in_valid_i,
    input  logic signed [DATA_W-1:0]      in_data_i,
    input  logic                          out_ready_i,
    output logic                          out_valid_o,
    output logic signed [DATA_W-1:0]      out_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o
);

    // Accumulator is wide enough to hold a full block sum without overflow.
    localparam int ACC_W = DATA_W + DECIM_LOG2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [DECIM_LOG2-1:0] CNT_MAX  = '1;
    localparam logic [DECIM_LOG2-1:0] CNT_ONE  = DECIM_LOG2'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [LVL_W-1:0]      LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Block accumulator signals
    // ------------------------------------------------------------------
    logic [DECIM_LOG2-1:0]   cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum;
    logic signed [DATA_W-1:0] result;
    logic                    block_done;

    // ------------------------------------------------------------------
    // Output FIFO signals
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]         level_q,  level_d;
    logic                     overflow_q, overflow_d;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     pop;
    logic                     push;
    logic                     drop;

    // Block accumulation: running sum, sample count and the block result.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        in_ext     = {{DECIM_LOG2{in_data_i[DATA_W-1]}}, in_data_i};
        sum        = acc_q + in_ext;
        // Dropping the low DECIM_LOG2 bits of the signed sum is an arithmetic
        // shift right, i.e. floor division by the block size. The mean of
        // DATA_W-bit samples always fits back into DATA_W bits.
        result     = sum[ACC_W-1:DECIM_LOG2];
        block_done = in_valid_i && !clr_i && (cnt_q == CNT_MAX);

        if (clr_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (in_valid_i) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                acc_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
                acc_d = sum;
            end
        end
    end

    // FIFO control: push/pop decisions, pointer and level updates, overflow.
    always_comb begin
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LVL_FULL);
        // A full FIFO still accepts a push when the head leaves at the same edge.
        pop        = !clr_i && !fifo_empty && out_ready_i;
        push       = block_done && (!fifo_full || pop);
        drop       = block_done && fifo_full && !pop;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q || drop;

        if (clr_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset; entries are only read while level_q says they are valid.
    always_ff @(posedge system1000) begin
        if (push) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    // Outputs are driven purely from registered state; no path from in_* to out_*.
    always_comb begin
        out_valid_o = !fifo_empty;
        out_data_o  = fifo_empty ? '0 : mem_q[rd_ptr_q];
        level_o     = level_q;
        overflow_o  = overflow_q;
    end

endmodule

// File: tb/tb_feedback_loop_decimator.sv
// Self-checking bench for feedback_loop_decimator: directed scenarios with
// literal expectations plus a long randomized run, all compared every cycle
// against a queue-based behavioural model of blocks, averages and the FIFO.
module tb_feedback_loop_decimator;

    localparam int DATA_W     = 8;
    localparam int DECIM_LOG2 = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int RATIO      = 1 << DECIM_LOG2;

    logic                     clk       = 1'b0;
    logic                     rst_n     = 1'b1;
    logic                     clr       = 1'b0;
    logic                     in_valid  = 1'b0;
    logic signed [DATA_W-1:0] in_data   = '0;
    logic                     out_ready = 1'b0;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic                     overflow;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: pending block samples, queued averages, sticky flag.
    int blk[$];
    int mq[$];
    int popped[$];
    bit m_ovf  = 1'b0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    feedback_loop_decimator #(
        .DATA_W    (DATA_W),
        .DECIM_LOG2(DECIM_LOG2),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .system1000     (clk),
        .system1000_rstn(rst_n),
        .clr_i          (clr),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .out_ready_i    (out_ready),
        .out_valid_o    (out_valid),
        .out_data_o     (out_data),
        .level_o        (level),
        .overflow_o     (overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Floor of the arithmetic mean, from integer division.
    function automatic int floor_avg(input int s);
        int q;
        q = s / RATIO;
        if ((s % RATIO) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int m_head();
        return (mq.size() != 0) ? mq[0] : 0;
    endfunction

    task automatic model_step();
        int sum;
        if (clr) begin
            blk.delete();
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (in_valid) begin
                blk.push_back(int'(in_data));
                if (blk.size() == RATIO) begin
                    sum = 0;
                    foreach (blk[i]) sum += blk[i];
                    blk.delete();
                    if (mq.size() < FIFO_DEPTH) mq.push_back(floor_avg(sum));
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    // Reference model advances on the same edges as the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk.delete();
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            model_step();
        end
    end

    // Records every value handed to the consumer.
    always @(posedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) popped.push_back(int'(out_data));
    end

    // Compare process: outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid", int'(out_valid), (mq.size() != 0) ? 1 : 0);
            check("data", int'(out_data), m_head());
            check("level", int'(level), mq.size());
            check("overflow", int'(overflow), int'(m_ovf));
        end
    end

    // Apply inputs for one cycle, returning at the following falling edge.
    task automatic drive(input bit v, input int d, input bit r, input bit c);
        in_valid  = v;
        in_data   = DATA_W'(d);
        out_ready = r;
        clr       = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) drive(1'b0, 0, r, 1'b0);
    endtask

    task automatic blk4(input int a, input int b, input int c, input int d, input bit r);
        drive(1'b1, a, r, 1'b0);
        drive(1'b1, b, r, 1'b0);
        drive(1'b1, c, r, 1'b0);
        drive(1'b1, d, r, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_data"}, int'(out_data), 0);
        check({tag, "_level"}, int'(level), 0);
        check({tag, "_ovf"}, int'(overflow), 0);
    endtask

    int vec [4][5] = '{
        '{-1, -2, -3, -4, -3},
        '{127, 127, 127, 127, 127},
        '{-128, -128, -128, -128, -128},
        '{127, -128, 127, -128, -1}
    };
    int exp_full [5] = '{1, 2, 3, 4, 9};

    initial begin
        // Reset
        #1 rst_n = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        check_zero_outputs("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Positive block: 1,2,3,4 -> 2, visible one cycle after the 4th sample edge
        blk4(1, 2, 3, 4, 1'b1);
        check("pos_valid", int'(out_valid), 1);
        check("pos_data", int'(out_data), 2);
        check("pos_model", m_head(), 2);
        idle(1, 1'b1);
        check("pos_level_after_pop", int'(level), 0);

        // Negative and extreme blocks
        for (int t = 0; t < 4; t++) begin
            blk4(vec[t][0], vec[t][1], vec[t][2], vec[t][3], 1'b1);
            check("ext_data", int'(out_data), vec[t][4]);
            check("ext_model", m_head(), vec[t][4]);
            idle(1, 1'b1);
        end

        // Gapped input
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8, 1'b0, 1'b0);
            idle(3, 1'b0);
        end
        check("gap_no_output", int'(out_valid), 0);
        drive(1'b1, 8, 1'b0, 1'b0);
        check("gap_valid", int'(out_valid), 1);
        check("gap_data", int'(out_data), 8);
        idle(1, 1'b1);

        // Backpressure and overflow: averages 1..5, 5 is lost
        for (int k = 1; k <= 5; k++) blk4(k, k, k, k, 1'b0);
        check("ovf_level", int'(level), 4);
        check("ovf_flag", int'(overflow), 1);
        check("ovf_model_level", mq.size(), 4);
        popped.delete();
        idle(4, 1'b1);
        check("ovf_pop_count", popped.size(), 4);
        for (int i = 0; i < popped.size() && i < 4; i++) check("ovf_pop_order", popped[i], i + 1);
        check("ovf_sticky", int'(overflow), 1);
        check("ovf_drained", int'(out_valid), 0);

        // Full FIFO with pop at the same edge as the push of 9
        drive(1'b0, 0, 1'b0, 1'b1);
        check("clr_ovf", int'(overflow), 0);
        for (int k = 1; k <= 4; k++) blk4(k, k, k, k, 1'b0);
        popped.delete();
        drive(1'b1, 9, 1'b0, 1'b0);
        drive(1'b1, 9, 1'b0, 1'b0);
        drive(1'b1, 9, 1'b0, 1'b0);
        drive(1'b1, 9, 1'b1, 1'b0);
        check("full_pop_level", int'(level), 4);
        check("full_pop_ovf", int'(overflow), 0);
        idle(4, 1'b1);
        check("full_pop_count", popped.size(), 5);
        for (int i = 0; i < popped.size() && i < 5; i++) check("full_pop_order", popped[i], exp_full[i]);

        // Clear mid-block (the sample presented with clr is discarded)
        popped.delete();
        drive(1'b1, 100, 1'b1, 1'b0);
        drive(1'b1, 100, 1'b1, 1'b0);
        drive(1'b1, 100, 1'b1, 1'b1);
        blk4(4, 4, 4, 4, 1'b1);
        check("clr_data", int'(out_data), 4);
        idle(2, 1'b1);
        check("clr_pop_count", popped.size(), 1);
        if (popped.size() != 0) check("clr_pop_value", popped[0], 4);

        // Reset mid-block, with a queued result present
        popped.delete();
        blk4(20, 20, 20, 20, 1'b0);
        drive(1'b1, 100, 1'b0, 1'b0);
        drive(1'b1, 100, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs("rst_mid");
        @(negedge clk);
        #2 rst_n = 1'b1;
        blk4(4, 4, 4, 4, 1'b1);
        check("rst_data", int'(out_data), 4);
        idle(2, 1'b1);
        check("rst_pop_count", popped.size(), 1);
        if (popped.size() != 0) check("rst_pop_value", popped[0], 4);

        // Randomized traffic with varying backpressure and rare clears
        for (int i = 0; i < 4000; i++) begin
            drive(1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 99) < ((i < 2000) ? 20 : 85)),
                  ($urandom_range(0, 299) == 0));
        end
        idle(8, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
